// File: rtl/multicycle_control.sv
// Purpose : Moore control FSM for a multicycle MIPS-style datapath (lw/sw/R-type/beq/addi/j).
// Latency : lw 5 cycles; sw, R-type, addi 4; beq, j 3; unknown opcode 2. All outputs follow the state register.
// Backpressure: none; the FSM advances on every rising clk edge.
// Ports   : clk, resetn (async, active low); Op/Funct from the instruction register; Zero from the ALU.
//           Controls IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB[1:0],
//           PCSrc[1:0], PCEn, AluCon[2:0]; State[3:0] exposes the current state for debug.
// Option  : define BNE_EN to add bne (opcode 000101), which branches when Zero is clear.
module multicycle_control (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [2:0] AluCon,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    state_t     r_state;
    state_t     w_next;

    logic       w_pc_write;
    logic       w_branch;
    logic       w_take;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic [1:0] w_alu_op;

    // State register; reset lands in FETCH immediately, even mid-instruction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = DECODE;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = EXECUTE;
                    OP_BEQ:       w_next = BRANCH;
`ifdef BNE_EN
                    OP_BNE:       w_next = BRANCH;
`endif
                    OP_ADDI:      w_next = ADDIEX;
                    OP_J:         w_next = JUMP;
                    default:      w_next = FETCH;
                endcase
            end
            MEMADR: begin
                if (Op == OP_LW) begin
                    w_next = MEMRD;
                end else if (Op == OP_SW) begin
                    w_next = MEMWR;
                end else begin
                    w_next = FETCH;
                end
            end
            MEMRD:   w_next = MEMWB;
            MEMWB:   w_next = FETCH;
            MEMWR:   w_next = FETCH;
            EXECUTE: w_next = ALUWB;
            ALUWB:   w_next = FETCH;
            BRANCH:  w_next = FETCH;
            ADDIEX:  w_next = ADDIWB;
            ADDIWB:  w_next = FETCH;
            JUMP:    w_next = FETCH;
            default: w_next = FETCH;   // encodings 12-15 recover to FETCH
        endcase
    end

    // Moore output decode from the state alone.
    always_comb begin
        IorD        = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        w_reg_write = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        w_alu_op    = 2'b00;
        case (r_state)
            FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                ALUSrcB    = 2'b01;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                IorD = 1'b1;
            end
            MEMWB: begin
                w_reg_write = 1'b1;
                MemtoReg    = 1'b1;
            end
            MEMWR: begin
                IorD        = 1'b1;
                w_mem_write = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA  = 1'b1;
                w_alu_op = 2'b10;
            end
            ALUWB: begin
                RegDst      = 1'b1;
                w_reg_write = 1'b1;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                PCSrc    = 2'b01;
                w_branch = 1'b1;
                w_alu_op = 2'b01;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB: begin
                w_reg_write = 1'b1;
            end
            JUMP: begin
                PCSrc      = 2'b10;
                w_pc_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ALU decode: fixed add/sub for address and branch compare, funct-driven for R-type.
    always_comb begin
        AluCon = 3'b010;
        case (w_alu_op)
            2'b01: AluCon = 3'b110;
            2'b10: begin
                case (Funct)
                    6'b100000: AluCon = 3'b010;
                    6'b100010: AluCon = 3'b110;
                    6'b100100: AluCon = 3'b000;
                    6'b100101: AluCon = 3'b001;
                    6'b101010: AluCon = 3'b111;
                    default:   AluCon = 3'b010;
                endcase
            end
            default: AluCon = 3'b010;
        endcase
    end

    // Branch condition; Op is held in the instruction register through BRANCH.
`ifdef BNE_EN
    assign w_take = (Op == OP_BNE) ? ~Zero : Zero;
`else
    assign w_take = Zero;
`endif

    // Write strobes are held off while resetn is low; the state is already FETCH then.
    assign MemWrite = w_mem_write & resetn;
    assign IRWrite  = w_ir_write  & resetn;
    assign RegWrite = w_reg_write & resetn;
    assign PCEn     = resetn & (w_pc_write | (w_branch & w_take));
    assign State    = r_state;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
- REQ-001: Parameters: none; opcode and funct encodings are fixed by REQ-012 and REQ-015.
- REQ-002: clk  input  1  rising-edge clock.
- REQ-003: resetn  input  1  asynchronous, active-low reset.
- REQ-004: Op  input  6  opcode field from the instruction register (instr[31:26]).
- REQ-005: Funct  input  6  funct field from the instruction register (instr[5:0]).
- REQ-006: Zero  input  1  ALU zero flag (ALUres == 0), same cycle.
- REQ-007: Outputs, all 1 bit: IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn.
- REQ-008: Outputs, 2 bits each: ALUSrcB (00 reg B, 01 const 4, 10 signimm, 11 signimm<<2) and PCSrc (00 ALUres, 01 ALUOut, 10 jump target).
- REQ-009: AluCon  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- REQ-010: State  output  4  current state encoding, for debug only.

Function
- REQ-011: The block shall be a Moore FSM: a registered 4-bit state, with all outputs decoded combinationally from the state except PCEn and AluCon.
- REQ-012: States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- REQ-013: Transitions from FETCH:
  - FETCH->DECODE unconditionally.
  - DECODE->MEMADR for lw (100011) or sw (101011).
  - DECODE->EXECUTE for R-type (000000).
  - DECODE->BRANCH for beq (000100).
  - DECODE->ADDIEX for addi (001000).
  - DECODE->JUMP for j (000010).
  - DECODE->FETCH for any other opcode (no writes performed).
- REQ-014: Remaining transitions:
  - MEMADR->MEMRD for lw; MEMADR->MEMWR for sw.
  - MEMRD->MEMWB->FETCH.
  - MEMWR->FETCH; EXECUTE->ALUWB->FETCH.
  - BRANCH->FETCH; ADDIEX->ADDIWB->FETCH; JUMP->FETCH.
  - Undefined encodings 12-15 ->FETCH.
- REQ-015: Internal ALUOp shall be 00 in FETCH, DECODE, MEMADR and ADDIEX; 01 in BRANCH; 10 in EXECUTE.
- REQ-016: AluCon decode:
  - ALUOp 00 -> 010; ALUOp 01 -> 110.
  - ALUOp 10 by Funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other->010.
- REQ-017: Per-state asserted outputs (all others 0):
  - FETCH: IRWrite, PCWrite, ALUSrcB=01.
  - DECODE: ALUSrcB=11.
  - MEMADR: ALUSrcA, ALUSrcB=10.
  - MEMRD: IorD.
  - MEMWB: RegWrite, MemtoReg.
  - MEMWR: IorD, MemWrite.
  - EXECUTE: ALUSrcA.
  - ALUWB: RegDst, RegWrite.
  - BRANCH: ALUSrcA, PCSrc=01, Branch.
  - ADDIEX: ALUSrcA, ALUSrcB=10.
  - ADDIWB: RegWrite.
  - JUMP: PCSrc=10, PCWrite.
- REQ-018: PCEn shall equal PCWrite | (Branch & Zero), combinational with Zero in the same cycle.
- REQ-019: Instruction latency: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles; unknown opcode 2 cycles.

Reset
- REQ-020: Asserting resetn low shall force State to FETCH asynchronously, at any point mid-instruction.
- REQ-021: While resetn is low, MemWrite, IRWrite, RegWrite and PCEn shall be forced to 0; all other outputs shall take their FETCH values.
- REQ-022: On the first rising clk edge after resetn goes high, FETCH shall be executed with all writes enabled.

Configuration
- REQ-023: With macro BNE_EN defined, DECODE->BRANCH shall also occur for opcode 000101, and for bne PCEn shall equal Branch & ~Zero; the latched Op selects the polarity.
- REQ-024: Without BNE_EN, opcode 000101 shall be treated as unknown (DECODE->FETCH).

Verification
- REQ-025: Reset, then Op=100011 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
- REQ-026: Op=000000, Funct=100010 -> in EXECUTE, AluCon=110 and ALUSrcA=1; in ALUWB, RegDst=1 and RegWrite=1; Funct=101010 -> AluCon=111.
- REQ-027: Op=000100 with Zero=1 in BRANCH -> PCEn=1, PCSrc=01; repeat with Zero=0 -> PCEn=0; both return to FETCH.
- REQ-028: Op=111111 -> states 0,1,0 with no MemWrite, RegWrite or PCEn in DECODE.
- REQ-029: resetn pulsed low during MEMWR -> State=0 immediately and MemWrite=0 while low; FETCH resumes after release.
- REQ-030: With BNE_EN, Op=000101 and Zero=0 in BRANCH -> PCEn=1; without BNE_EN -> states 0,1,0.
